// File: rtl/wb_pkg.sv
// Shared types for the writeback controller: commit request, arbiter state
// and default widths.
package wb_pkg;

    localparam int unsigned DEF_REG_WIDTH  = 32;
    localparam int unsigned DEF_NUM_REGS   = 32;
    localparam int unsigned DEF_ADDR_WIDTH = $clog2(DEF_NUM_REGS);
    localparam int unsigned DEF_FIFO_DEPTH = 4;

    typedef struct packed {
        logic [DEF_ADDR_WIDTH-1:0] rd;
        logic [DEF_REG_WIDTH-1:0]  data;
    } wb_req_t;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_ALU_FIRST,
        ARB_FIFO_DRAIN,
        ARB_FULL_DRAIN
    } wb_arb_e;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO of commit requests. Pointers carry one extra wrap bit, so
// full and empty are distinguished without a separate counter.
module wb_fifo
    import wb_pkg::*;
#(
    parameter type         T     = wb_req_t,
    parameter int unsigned DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  T                         push_data,
    input  logic                     pop,
    output T                         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam logic [PW:0] PTR_ONE = 1;

    logic [PW:0] r_wr_ptr;
    logic [PW:0] r_rd_ptr;
    T            r_mem [DEPTH];

    logic w_do_push;
    logic w_do_pop;

    assign empty     = (r_wr_ptr == r_rd_ptr);
    assign full      = (r_wr_ptr[PW] != r_rd_ptr[PW]) &&
                       (r_wr_ptr[PW-1:0] == r_rd_ptr[PW-1:0]);
    assign count     = r_wr_ptr - r_rd_ptr;
    assign pop_data  = r_mem[r_rd_ptr[PW-1:0]];
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[PW-1:0]] <= push_data;
    end

endmodule

// File: rtl/writeback_controller.sv
// Register-file writeback: arbitrates ALU and buffered load results into one
// registered write per cycle, keeps a pending-write scoreboard and (with
// WRITEBACK_BYPASS_EN defined) forwards the committing value to decode.
module writeback_controller
    import wb_pkg::*;
#(
    parameter int unsigned REG_WIDTH       = DEF_REG_WIDTH,
    parameter int unsigned NUM_REGS        = DEF_NUM_REGS,
    parameter int unsigned ADDR_WIDTH      = $clog2(NUM_REGS),
    parameter int unsigned FIFO_DEPTH      = DEF_FIFO_DEPTH,
    parameter bit          REG_ZERO_GROUND = 1'b1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        alu_valid,
    output logic                        alu_ready,
    input  logic [ADDR_WIDTH-1:0]       alu_rd,
    input  logic [REG_WIDTH-1:0]        alu_data,
    input  logic                        mem_valid,
    output logic                        mem_ready,
    input  logic [ADDR_WIDTH-1:0]       mem_rd,
    input  logic [REG_WIDTH-1:0]        mem_data,
    output logic                        write_enable,
    output logic [ADDR_WIDTH-1:0]       write_addr,
    output logic [REG_WIDTH-1:0]        write_data,
    input  logic                        reserve_valid,
    input  logic [ADDR_WIDTH-1:0]       reserve_addr,
    output logic [NUM_REGS-1:0]         busy_mask,
    input  logic [ADDR_WIDTH-1:0]       read_addr_0,
    input  logic [ADDR_WIDTH-1:0]       read_addr_1,
    output logic                        fwd_valid_0,
    output logic                        fwd_valid_1,
    output logic [REG_WIDTH-1:0]        fwd_data_0,
    output logic [REG_WIDTH-1:0]        fwd_data_1,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] rd;
        logic [REG_WIDTH-1:0]  data;
    } req_t;

    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_write_addr;
    logic [REG_WIDTH-1:0]  r_write_data;
    logic [NUM_REGS-1:0]   r_busy;

    logic                  w_fifo_full;
    logic                  w_fifo_empty;
    logic                  w_push;
    logic                  w_pop;
    req_t                  w_push_req;
    req_t                  w_head;
    req_t                  w_commit;
    logic                  w_commit_valid;
    logic                  w_write_ok;
    wb_arb_e               w_arb;
    logic [NUM_REGS-1:0]   w_busy_next;

    assign w_push_req = '{rd: mem_rd, data: mem_data};
    assign mem_ready  = !w_fifo_full;
    assign w_push     = mem_valid && !w_fifo_full;

    wb_fifo #(
        .T     (req_t),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (w_push),
        .push_data (w_push_req),
        .pop       (w_pop),
        .pop_data  (w_head),
        .full      (w_fifo_full),
        .empty     (w_fifo_empty),
        .count     (fifo_count)
    );

    // A full FIFO outranks the ALU so loads cannot be starved indefinitely.
    always_comb begin
        w_arb = ARB_IDLE;
        if (w_fifo_full)        w_arb = ARB_FULL_DRAIN;
        else if (alu_valid)     w_arb = ARB_ALU_FIRST;
        else if (!w_fifo_empty) w_arb = ARB_FIFO_DRAIN;
    end

    assign alu_ready      = (w_arb == ARB_ALU_FIRST);
    assign w_pop          = (w_arb == ARB_FULL_DRAIN) || (w_arb == ARB_FIFO_DRAIN);
    assign w_commit_valid = (w_arb != ARB_IDLE);
    assign w_commit       = (w_arb == ARB_ALU_FIRST) ? '{rd: alu_rd, data: alu_data} : w_head;
    assign w_write_ok     = w_commit_valid && !(REG_ZERO_GROUND && (w_commit.rd == '0));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_we         <= 1'b0;
            r_write_addr <= '0;
            r_write_data <= '0;
        end else begin
            r_we <= w_write_ok;
            if (w_write_ok) begin
                r_write_addr <= w_commit.rd;
                r_write_data <= w_commit.data;
            end
        end
    end

    // Clear is applied before set so a same-cycle reserve of the committing
    // register keeps it busy.
    always_comb begin
        w_busy_next = r_busy;
        if (r_we) w_busy_next[r_write_addr] = 1'b0;
        if (reserve_valid && !(REG_ZERO_GROUND && (reserve_addr == '0)))
            w_busy_next[reserve_addr] = 1'b1;
        if (REG_ZERO_GROUND) w_busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) r_busy <= '0;
        else     r_busy <= w_busy_next;
    end

    assign write_enable = r_we;
    assign write_addr   = r_write_addr;
    assign write_data   = r_write_data;
    assign busy_mask    = r_busy;

`ifdef WRITEBACK_BYPASS_EN
    assign fwd_valid_0 = r_we && (r_write_addr == read_addr_0);
    assign fwd_valid_1 = r_we && (r_write_addr == read_addr_1);
    assign fwd_data_0  = r_write_data;
    assign fwd_data_1  = r_write_data;
`else
    logic w_unused_read_addr;
    assign w_unused_read_addr = ^{read_addr_0, read_addr_1};
    assign fwd_valid_0 = 1'b0;
    assign fwd_valid_1 = 1'b0;
    assign fwd_data_0  = '0;
    assign fwd_data_1  = '0;
`endif

endmodule

// File: tb/tb_writeback_controller.sv
// Self-checking bench for writeback_controller: directed scenarios plus a
// randomized run against a queue-based reference model.
module tb_writeback_controller;

    localparam int D = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid, alu_ready;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        mem_valid, mem_ready;
    logic [4:0]  mem_rd;
    logic [31:0] mem_data;
    logic        write_enable;
    logic [4:0]  write_addr;
    logic [31:0] write_data;
    logic        reserve_valid;
    logic [4:0]  reserve_addr;
    logic [31:0] busy_mask;
    logic [4:0]  read_addr_0, read_addr_1;
    logic        fwd_valid_0, fwd_valid_1;
    logic [31:0] fwd_data_0, fwd_data_1;
    logic [2:0]  fifo_count;

    always #5 clk = ~clk;

    writeback_controller #(
        .REG_WIDTH       (32),
        .NUM_REGS        (32),
        .FIFO_DEPTH      (D),
        .REG_ZERO_GROUND (1'b1)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .alu_valid     (alu_valid),
        .alu_ready     (alu_ready),
        .alu_rd        (alu_rd),
        .alu_data      (alu_data),
        .mem_valid     (mem_valid),
        .mem_ready     (mem_ready),
        .mem_rd        (mem_rd),
        .mem_data      (mem_data),
        .write_enable  (write_enable),
        .write_addr    (write_addr),
        .write_data    (write_data),
        .reserve_valid (reserve_valid),
        .reserve_addr  (reserve_addr),
        .busy_mask     (busy_mask),
        .read_addr_0   (read_addr_0),
        .read_addr_1   (read_addr_1),
        .fwd_valid_0   (fwd_valid_0),
        .fwd_valid_1   (fwd_valid_1),
        .fwd_data_0    (fwd_data_0),
        .fwd_data_1    (fwd_data_1),
        .fifo_count    (fifo_count)
    );

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    ent_t        mq[$];
    logic        m_we;
    logic [4:0]  m_addr;
    logic [31:0] m_data;
    logic [31:0] m_busy;
    int          checks = 0;
    int          errors = 0;

    // Advance the model by one edge using the current inputs, then the DUT.
    task automatic tick();
        ent_t c;
        bit   have;
        int   sz;
        if (rst) begin
            mq.delete();
            m_we = 0; m_addr = '0; m_data = '0; m_busy = '0;
        end else begin
            sz = mq.size();
            have = 0;
            if (sz == D) begin c = mq.pop_front(); have = 1; end
            else if (alu_valid) begin c.rd = alu_rd; c.data = alu_data; have = 1; end
            else if (sz > 0) begin c = mq.pop_front(); have = 1; end
            if (mem_valid && sz < D) mq.push_back('{mem_rd, mem_data});
            if (m_we) m_busy[m_addr] = 1'b0;
            if (reserve_valid && reserve_addr != 5'd0) m_busy[reserve_addr] = 1'b1;
            m_we = have && (c.rd != 5'd0);
            if (m_we) begin m_addr = c.rd; m_data = c.data; end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        alu_valid = 0; alu_rd = '0; alu_data = '0;
        mem_valid = 0; mem_rd = '0; mem_data = '0;
        reserve_valid = 0; reserve_addr = '0;
    endtask

    function automatic bit exp_fv(input logic [4:0] ra);
`ifdef WRITEBACK_BYPASS_EN
        return m_we && (m_addr == ra);
`else
        return ra == 5'd31 && 1'b0;
`endif
    endfunction

    task automatic test_reset();
        rst = 1; idle_inputs(); read_addr_0 = '0; read_addr_1 = '0;
        tick(); tick();
        checks++; if (write_enable !== 1'b0) begin errors++; $display("FAIL reset_we got %b exp 0", write_enable); end
        checks++; if (write_addr !== 5'd0) begin errors++; $display("FAIL reset_addr got %0d exp 0", write_addr); end
        checks++; if (write_data !== 32'd0) begin errors++; $display("FAIL reset_data got %h exp 0", write_data); end
        checks++; if (busy_mask !== 32'd0) begin errors++; $display("FAIL reset_busy got %h exp 0", busy_mask); end
        checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", fifo_count); end
        checks++; if (mem_ready !== 1'b1) begin errors++; $display("FAIL reset_mem_ready got %b exp 1", mem_ready); end
        rst = 0;
    endtask

    task automatic test_single_alu();
        reserve_valid = 1; reserve_addr = 5'd5;
        tick();
        reserve_valid = 0;
        checks++; if (busy_mask[5] !== 1'b1) begin errors++; $display("FAIL alu_busy_set got %b exp 1", busy_mask[5]); end
        alu_valid = 1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
        #1;
        checks++; if (alu_ready !== 1'b1) begin errors++; $display("FAIL alu_ready got %b exp 1", alu_ready); end
        tick();
        alu_valid = 0;
        checks++; if ({write_enable, write_addr, write_data} !== {1'b1, 5'd5, 32'hDEADBEEF}) begin
            errors++; $display("FAIL alu_commit got we=%b a=%0d d=%h exp we=1 a=5 d=deadbeef", write_enable, write_addr, write_data); end
        checks++; if (busy_mask[5] !== 1'b1) begin errors++; $display("FAIL alu_busy_hold got %b exp 1", busy_mask[5]); end
        tick();
        checks++; if (busy_mask[5] !== 1'b0) begin errors++; $display("FAIL alu_busy_clear got %b exp 0", busy_mask[5]); end
        checks++; if (write_enable !== 1'b0) begin errors++; $display("FAIL alu_we_drop got %b exp 0", write_enable); end
    endtask

    task automatic test_contention();
        alu_valid = 1; alu_rd = 5'd3; alu_data = 32'h33;
        mem_valid = 1; mem_rd = 5'd4; mem_data = 32'h44;
        #1;
        checks++; if ({alu_ready, mem_ready} !== 2'b11) begin errors++; $display("FAIL cont_ready got %b exp 11", {alu_ready, mem_ready}); end
        tick();
        idle_inputs();
        checks++; if ({write_enable, write_addr, write_data, fifo_count} !== {1'b1, 5'd3, 32'h33, 3'd1}) begin
            errors++; $display("FAIL cont_first got we=%b a=%0d d=%h cnt=%0d exp 1/3/33/1", write_enable, write_addr, write_data, fifo_count); end
        tick();
        checks++; if ({write_enable, write_addr, write_data, fifo_count} !== {1'b1, 5'd4, 32'h44, 3'd0}) begin
            errors++; $display("FAIL cont_second got we=%b a=%0d d=%h cnt=%0d exp 1/4/44/0", write_enable, write_addr, write_data, fifo_count); end
        tick();
        checks++; if (write_enable !== 1'b0) begin errors++; $display("FAIL cont_idle got %b exp 0", write_enable); end
    endtask

    task automatic test_full_fifo();
        for (int i = 0; i < D; i++) begin
            alu_valid = 1; alu_rd = 5'(10 + i); alu_data = 32'(32'h100 + i);
            mem_valid = 1; mem_rd = 5'(20 + i); mem_data = 32'(32'h200 + i);
            #1;
            checks++; if ({alu_ready, mem_ready} !== 2'b11) begin errors++; $display("FAIL fill_ready[%0d] got %b exp 11", i, {alu_ready, mem_ready}); end
            tick();
            checks++; if ({write_addr, fifo_count} !== {5'(10 + i), 3'(i + 1)}) begin
                errors++; $display("FAIL fill_step[%0d] got a=%0d cnt=%0d exp a=%0d cnt=%0d", i, write_addr, fifo_count, 10 + i, i + 1); end
        end
        mem_valid = 0; alu_rd = 5'd14; alu_data = 32'h114;
        #1;
        checks++; if ({mem_ready, alu_ready, fifo_count} !== {1'b0, 1'b0, 3'd4}) begin
            errors++; $display("FAIL full_state got mr=%b ar=%b cnt=%0d exp 0/0/4", mem_ready, alu_ready, fifo_count); end
        tick();
        checks++; if ({write_enable, write_addr, write_data, fifo_count} !== {1'b1, 5'd20, 32'h200, 3'd3}) begin
            errors++; $display("FAIL full_drain got we=%b a=%0d d=%h cnt=%0d exp 1/20/200/3", write_enable, write_addr, write_data, fifo_count); end
        #1;
        checks++; if ({mem_ready, alu_ready} !== 2'b11) begin errors++; $display("FAIL full_recover got %b exp 11", {mem_ready, alu_ready}); end
        tick();
        alu_valid = 0;
        checks++; if ({write_addr, write_data, fifo_count} !== {5'd14, 32'h114, 3'd3}) begin
            errors++; $display("FAIL full_alu got a=%0d d=%h cnt=%0d exp 14/114/3", write_addr, write_data, fifo_count); end
        for (int i = 1; i < D; i++) begin
            tick();
            checks++; if ({write_enable, write_addr, fifo_count} !== {1'b1, 5'(20 + i), 3'(D - 1 - i)}) begin
                errors++; $display("FAIL drain[%0d] got we=%b a=%0d cnt=%0d exp 1/%0d/%0d", i, write_enable, write_addr, fifo_count, 20 + i, D - 1 - i); end
        end
        tick();
    endtask

    task automatic test_ground();
        alu_valid = 1; alu_rd = 5'd0; alu_data = 32'h1;
        reserve_valid = 1; reserve_addr = 5'd0;
        #1;
        checks++; if (alu_ready !== 1'b1) begin errors++; $display("FAIL gnd_ready got %b exp 1", alu_ready); end
        tick();
        idle_inputs();
        checks++; if (write_enable !== 1'b0) begin errors++; $display("FAIL gnd_we got %b exp 0", write_enable); end
        checks++; if (busy_mask[0] !== 1'b0) begin errors++; $display("FAIL gnd_busy got %b exp 0", busy_mask[0]); end
        tick();
    endtask

    task automatic test_race();
        reserve_valid = 1; reserve_addr = 5'd7;
        tick();
        reserve_valid = 0;
        alu_valid = 1; alu_rd = 5'd7; alu_data = 32'h77;
        tick();
        alu_valid = 0;
        checks++; if ({write_enable, write_addr} !== {1'b1, 5'd7}) begin errors++; $display("FAIL race_commit got we=%b a=%0d exp 1/7", write_enable, write_addr); end
        reserve_valid = 1; reserve_addr = 5'd7;
        tick();
        reserve_valid = 0;
        checks++; if (busy_mask[7] !== 1'b1) begin errors++; $display("FAIL race_busy got %b exp 1", busy_mask[7]); end
        alu_valid = 1; alu_rd = 5'd7; alu_data = 32'h78;
        tick();
        alu_valid = 0;
        tick();
        checks++; if (busy_mask[7] !== 1'b0) begin errors++; $display("FAIL race_clear got %b exp 0", busy_mask[7]); end
    endtask

    task automatic test_forward();
        logic        ev;
        logic [31:0] ed;
`ifdef WRITEBACK_BYPASS_EN
        ev = 1'b1; ed = 32'h55;
`else
        ev = 1'b0; ed = 32'h0;
`endif
        alu_valid = 1; alu_rd = 5'd9; alu_data = 32'h55;
        read_addr_0 = 5'd2; read_addr_1 = 5'd9;
        tick();
        alu_valid = 0;
        checks++; if ({fwd_valid_1, fwd_data_1} !== {ev, ed}) begin
            errors++; $display("FAIL fwd_port1 got v=%b d=%h exp v=%b d=%h", fwd_valid_1, fwd_data_1, ev, ed); end
        checks++; if (fwd_valid_0 !== 1'b0) begin errors++; $display("FAIL fwd_port0 got %b exp 0", fwd_valid_0); end
        alu_valid = 1; alu_rd = 5'd13; alu_data = 32'h13;
        mem_valid = 1; mem_rd = 5'd11; mem_data = 32'h11;
        reserve_valid = 1; reserve_addr = 5'd12;
        tick();
        idle_inputs();
        read_addr_0 = 5'd13; rst = 1;
        tick();
        checks++; if ({write_enable, write_addr, write_data, busy_mask, fifo_count} !== '0) begin
            errors++; $display("FAIL midrst_state got we=%b a=%0d d=%h busy=%h cnt=%0d exp all 0", write_enable, write_addr, write_data, busy_mask, fifo_count); end
        checks++; if ({fwd_valid_0, fwd_valid_1, fwd_data_0, fwd_data_1} !== '0) begin
            errors++; $display("FAIL midrst_fwd got v0=%b v1=%b d0=%h d1=%h exp 0", fwd_valid_0, fwd_valid_1, fwd_data_0, fwd_data_1); end
        rst = 0;
        tick();
        checks++; if (write_enable !== 1'b0) begin errors++; $display("FAIL midrst_nocommit got %b exp 0", write_enable); end
    endtask

    task automatic test_random();
        bit alu_hold, mem_hold;
        idle_inputs();
        for (int n = 0; n < 600; n++) begin
            rst = ($urandom_range(0, 149) == 0);
            if (!alu_hold) begin
                alu_valid = ($urandom_range(0, 9) < 6);
                alu_rd = 5'($urandom); alu_data = $urandom;
            end
            if (!mem_hold) begin
                mem_valid = ($urandom_range(0, 9) < 5);
                mem_rd = 5'($urandom); mem_data = $urandom;
            end
            reserve_valid = ($urandom_range(0, 3) == 0);
            reserve_addr = 5'($urandom);
            read_addr_0 = m_we && $urandom_range(0, 1) ? m_addr : 5'($urandom);
            read_addr_1 = 5'($urandom);
            #1;
            checks++; if (mem_ready !== (mq.size() < D)) begin
                errors++; $display("FAIL rnd_mem_ready[%0d] got %b exp %b", n, mem_ready, mq.size() < D); end
            if (alu_valid) begin
                checks++; if (alu_ready !== (mq.size() != D)) begin
                    errors++; $display("FAIL rnd_alu_ready[%0d] got %b exp %b", n, alu_ready, mq.size() != D); end
            end
            alu_hold = alu_valid && !(mq.size() != D) && !rst;
            mem_hold = mem_valid && !(mq.size() < D) && !rst;
            tick();
            checks++; if (write_enable !== m_we) begin errors++; $display("FAIL rnd_we[%0d] got %b exp %b", n, write_enable, m_we); end
            if (m_we) begin
                checks++; if ({write_addr, write_data} !== {m_addr, m_data}) begin
                    errors++; $display("FAIL rnd_write[%0d] got a=%0d d=%h exp a=%0d d=%h", n, write_addr, write_data, m_addr, m_data); end
            end
            checks++; if (busy_mask !== m_busy) begin errors++; $display("FAIL rnd_busy[%0d] got %h exp %h", n, busy_mask, m_busy); end
            checks++; if (fifo_count !== 3'(mq.size())) begin errors++; $display("FAIL rnd_count[%0d] got %0d exp %0d", n, fifo_count, mq.size()); end
            checks++; if ({fwd_valid_0, fwd_valid_1} !== {exp_fv(read_addr_0), exp_fv(read_addr_1)}) begin
                errors++; $display("FAIL rnd_fwd_valid[%0d] got %b%b exp %b%b", n, fwd_valid_0, fwd_valid_1, exp_fv(read_addr_0), exp_fv(read_addr_1)); end
            if (exp_fv(read_addr_0)) begin
                checks++; if (fwd_data_0 !== m_data) begin errors++; $display("FAIL rnd_fwd_data0[%0d] got %h exp %h", n, fwd_data_0, m_data); end
            end
        end
        rst = 0;
    endtask

    initial begin
        rst = 1;
        idle_inputs();
        read_addr_0 = '0; read_addr_1 = '0;
        m_we = 0; m_addr = '0; m_data = '0; m_busy = '0;
        @(posedge clk); #1;
        test_reset();
        test_single_alu();
        test_contention();
        test_full_fifo();
        test_ground();
        test_race();
        test_forward();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/writeback_controller.md
Name: writeback_controller

Overview:
- Drives the register file write port (write_enable / write_addr / write_data) from two producers: the single-cycle ALU and the variable-latency load unit.
- Load results are buffered in a small FIFO. One register write is committed per cycle.
- Keeps a per-register pending-write scoreboard that decode uses for RAW/WAW stalls.
- Forwards the value being committed this cycle to the decode read ports.

Parameters:
- REG_WIDTH, 32, data width of one register.
- NUM_REGS, 32, number of architectural registers.
- ADDR_WIDTH, $clog2(NUM_REGS), register address width.
- FIFO_DEPTH, 4, number of load-result buffer entries; must be a power of 2 and at least 2.
- REG_ZERO_GROUND, 1, when 1, register 0 is never written and never marked busy.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- alu_valid  in  1  ALU result present
- alu_ready  out  1  ALU result accepted this cycle
- alu_rd  in  ADDR_WIDTH  ALU destination register
- alu_data  in  REG_WIDTH  ALU result
- mem_valid  in  1  load result present
- mem_ready  out  1  FIFO can accept a load result
- mem_rd  in  ADDR_WIDTH  load destination register
- mem_data  in  REG_WIDTH  load result
- write_enable  out  1  register file write strobe (registered)
- write_addr  out  ADDR_WIDTH  register file write address (registered)
- write_data  out  REG_WIDTH  register file write data (registered)
- reserve_valid  in  1  decode issued an instruction with a destination
- reserve_addr  in  ADDR_WIDTH  destination register being reserved
- busy_mask  out  NUM_REGS  bit i = write pending to register i
- read_addr_0  in  ADDR_WIDTH  decode read port 0 address
- read_addr_1  in  ADDR_WIDTH  decode read port 1 address
- fwd_valid_0  out  1  fwd_data_0 overrides the register file read
- fwd_valid_1  out  1  fwd_data_1 overrides the register file read
- fwd_data_0  out  REG_WIDTH  forwarded data for port 0
- fwd_data_1  out  REG_WIDTH  forwarded data for port 1
- fifo_count  out  $clog2(FIFO_DEPTH)+1  number of occupied FIFO entries

Behaviour:
- Reset (rst=1 at a clk edge): write_enable=0, write_addr=0, write_data=0, busy_mask=0, FIFO emptied, fifo_count=0. Reset mid-operation discards all buffered results and pending bits.
- Handshakes: a transfer happens when valid&&ready at a clk edge. Producers hold rd/data stable while valid&&!ready.
- mem_ready = (fifo_count < FIFO_DEPTH). It is not dependent on a same-cycle pop. Push occurs on mem_valid&&mem_ready.
- Arbiter (combinational, one commit slot per cycle):
  - FULL_DRAIN: fifo_count==FIFO_DEPTH. The FIFO head commits and alu_ready=0.
  - ALU_FIRST: otherwise, if alu_valid, alu_ready=1 and the ALU commits; the FIFO holds.
  - FIFO_DRAIN: otherwise, if the FIFO is not empty, the head pops and commits.
  - IDLE: nothing commits.
- A push and a pop in the same cycle leave fifo_count unchanged. An empty-FIFO push is not bypassed; it commits no earlier than the next cycle.
- Commit latency: a result transferred at edge N drives write_enable=1 with its rd/data during cycle N..N+1. The register file captures it at edge N+1.
- If REG_ZERO_GROUND and rd==0, the handshake still completes but write_enable stays 0.
- Scoreboard:
  - Set: reserve_valid at an edge sets busy_mask[reserve_addr].
  - Clear: write_enable at an edge clears busy_mask[write_addr].
  - Set and clear to the same address in the same cycle: set wins.
  - reserve_addr==0 is ignored when grounded.
  - Decode stalls on a busy destination, so at most one write is outstanding per register.
- Forwarding: fwd_valid_k = write_enable && (write_addr==read_addr_k), and fwd_data_k = write_data. This is combinational from the registered outputs and covers the write-then-read-same-cycle hole. It is never asserted for address 0 when grounded.

Optional Feature:
- WRITEBACK_BYPASS_EN defined: the forwarding logic above is built.
- Not defined: fwd_valid_0/1=0 and fwd_data_0/1=0. Decode must stall one extra cycle after busy clears.

Decomposition:
- Package wb_pkg:
  - typedef wb_req_t {rd, data}.
  - Arbiter-state enum {IDLE, ALU_FIRST, FIFO_DRAIN, FULL_DRAIN}.
  - Default width constants.
- Sub-module wb_fifo: synchronous FIFO of wb_req_t with push, pop, full, empty and count. It uses wrap-around pointers with one extra bit.

Test Plan:
- Single ALU: alu_valid, rd=5, data=0xDEADBEEF. The next cycle shows write_enable=1, addr=5, data=0xDEADBEEF. busy[5], if reserved, clears after that edge.
- Contention: ALU rd=3 and mem rd=4 on the same cycle, then the ALU goes idle. Commits are rd=3 then rd=4. fifo_count goes 1 then 0.
- Full FIFO: 4 loads pushed while the ALU is continuously valid. mem_ready=0 at count=4, then alu_ready=0 for one cycle while the head drains, and mem_ready returns to 1.
- Ground: ALU rd=0, data=0x1. The handshake completes, write_enable stays 0, and busy[0] stays 0.
- Scoreboard race: reserve rd=7 on the same cycle as the commit to rd=7. busy[7] remains 1.
- Forward (WRITEBACK_BYPASS_EN): commit rd=9, data=0x55 with read_addr_1=9. fwd_valid_1=1 and fwd_data_1=0x55. Then assert rst mid-stream and check all outputs are 0 and fifo_count=0.
